// File: rtl/rx_block_lock.sv
// rx_block_lock
//   Receive-path block-lock FSM that sits directly after the Rx block-sync
//   gearbox. It classifies each 2-bit sync header and slips the gearbox
//   until a full window of clean headers is seen. It then forwards data and
//   headers downstream, qualified by lock.
//
// Ports
//   i_clk            clock
//   i_reset          synchronous active-high reset
//   i_rx_data        data word from gearbox
//   i_rx_data_valid  i_rx_data valid this cycle
//   i_rx_hdr         sync header from gearbox
//   i_rx_hdr_valid   i_rx_hdr valid this cycle (once per 66-bit block)
//   o_slip           one-cycle slip request to the gearbox
//   o_block_lock     block alignment achieved
//   o_rx_data        registered i_rx_data
//   o_rx_hdr         registered i_rx_hdr
//   o_rx_data_valid  registered i_rx_data_valid & o_block_lock
//   o_rx_hdr_valid   registered i_rx_hdr_valid & o_block_lock
module rx_block_lock #(
  parameter int DATA_WIDTH     = 32,
  parameter int HDR_WIDTH      = 2,
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVALID_MAX = 16,
  parameter int SLIP_WAIT_HDRS = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_data_valid,
  input  logic [HDR_WIDTH-1:0]  i_rx_hdr,
  input  logic                  i_rx_hdr_valid,
  output logic                  o_slip,
  output logic                  o_block_lock,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic [HDR_WIDTH-1:0]  o_rx_hdr,
  output logic                  o_rx_data_valid,
  output logic                  o_rx_hdr_valid
);

  localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVALID_MAX + 1);
  localparam int WAIT_W = (SLIP_WAIT_HDRS < 1) ? 1 : $clog2(SLIP_WAIT_HDRS + 1);

  localparam logic [SH_W-1:0]   SH_LAST  = SH_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]  INV_LAST = INV_W'(SH_INVALID_MAX);
  localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(SLIP_WAIT_HDRS);

  localparam logic [HDR_WIDTH-1:0] HDR_DATA = HDR_WIDTH'(2'b01);
  localparam logic [HDR_WIDTH-1:0] HDR_CTRL = HDR_WIDTH'(2'b10);

  typedef enum logic {
    TEST      = 1'b0,
    SLIP_WAIT = 1'b1
  } state_t;

  // registered copy of the gearbox word handed to the descrambler
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [HDR_WIDTH-1:0]  hdr;
    logic                  data_vld;
    logic                  hdr_vld;
  } rx_word_t;

  state_t            state_q, state_d;
  logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d;
  logic [INV_W-1:0]  inv_cnt_q, inv_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              lock_q, lock_d;
  logic              slip_q, slip_d;
  rx_word_t          word_q, word_d;

  logic              hdr_bad;
  logic [SH_W-1:0]   sh_nxt;
  logic [INV_W-1:0]  inv_nxt;
  logic [WAIT_W-1:0] wait_nxt;

  assign hdr_bad  = (i_rx_hdr != HDR_DATA) && (i_rx_hdr != HDR_CTRL);
  assign sh_nxt   = sh_cnt_q + SH_W'(1);
  assign inv_nxt  = inv_cnt_q + INV_W'(hdr_bad);
  assign wait_nxt = wait_cnt_q + WAIT_W'(1);

  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    inv_cnt_d  = inv_cnt_q;
    wait_cnt_d = wait_cnt_q;
    lock_d     = lock_q;
    slip_d     = 1'b0;
    unique case (state_q)
      TEST: begin
        if (i_rx_hdr_valid) begin
          // Unlocked: any bad header slips. Locked: only the window's
          // SH_INVALID_MAX-th bad header does. This takes priority over
          // window end.
          if (hdr_bad && (!lock_q || (inv_nxt >= INV_LAST))) begin
            slip_d    = 1'b1;
            lock_d    = 1'b0;
            sh_cnt_d  = '0;
            inv_cnt_d = '0;
            state_d   = SLIP_WAIT;
          end else if (sh_nxt == SH_LAST) begin
            // A clean window grants lock. A window with some errors keeps
            // the current lock state.
            if (inv_nxt == '0) lock_d = 1'b1;
            sh_cnt_d  = '0;
            inv_cnt_d = '0;
          end else begin
            sh_cnt_d  = sh_nxt;
            inv_cnt_d = inv_nxt;
          end
        end
      end
      SLIP_WAIT: begin
        // The headers seen here come from the pre-slip alignment or from a
        // gearbox that is still realigning, so they are counted and dropped.
        // Because this state lasts at least one cycle, slip pulses can
        // never be back to back.
        if (SLIP_WAIT_HDRS < 1) begin
          state_d = TEST;
        end else if (i_rx_hdr_valid) begin
          if (wait_nxt >= WAIT_END) begin
            wait_cnt_d = '0;
            state_d    = TEST;
          end else begin
            wait_cnt_d = wait_nxt;
          end
        end
      end
      default: state_d = TEST;
    endcase
  end

  // Valid gating uses the lock state held before this edge, so the block
  // that grants lock is not itself forwarded.
  always_comb begin
    word_d          = '0;
    word_d.data     = i_rx_data;
    word_d.hdr      = i_rx_hdr;
    word_d.data_vld = i_rx_data_valid & lock_q;
    word_d.hdr_vld  = i_rx_hdr_valid & lock_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= TEST;
      sh_cnt_q   <= '0;
      inv_cnt_q  <= '0;
      wait_cnt_q <= '0;
      lock_q     <= 1'b0;
      slip_q     <= 1'b0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      lock_q     <= lock_d;
      slip_q     <= slip_d;
      word_q     <= word_d;
    end
  end

  assign o_slip          = slip_q;
  assign o_block_lock    = lock_q;
  assign o_rx_data       = word_q.data;
  assign o_rx_hdr        = word_q.hdr;
  assign o_rx_data_valid = word_q.data_vld;
  assign o_rx_hdr_valid  = word_q.hdr_vld;

endmodule

// File: tb/tb_rx_block_lock.sv
// Testbench for rx_block_lock: directed scenarios plus randomized traffic,
// checked against a header-event reference model.
module tb_rx_block_lock;
  localparam int DW = 32;
  localparam int HW = 2;
  localparam int SH_MAX = 64;
  localparam int INV_MAX = 16;
  localparam int WAIT_HDRS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] rx_data = '0;
  logic          rx_dv = 1'b0;
  logic [HW-1:0] rx_hdr = '0;
  logic          rx_hv = 1'b0;
  logic          o_slip, o_block_lock, o_rx_data_valid, o_rx_hdr_valid;
  logic [DW-1:0] o_rx_data;
  logic [HW-1:0] o_rx_hdr;

  always #5 clk = ~clk;

  rx_block_lock #(
    .DATA_WIDTH(DW), .HDR_WIDTH(HW), .SH_CNT_MAX(SH_MAX),
    .SH_INVALID_MAX(INV_MAX), .SLIP_WAIT_HDRS(WAIT_HDRS)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_rx_data(rx_data), .i_rx_data_valid(rx_dv),
    .i_rx_hdr(rx_hdr), .i_rx_hdr_valid(rx_hv),
    .o_slip(o_slip), .o_block_lock(o_block_lock),
    .o_rx_data(o_rx_data), .o_rx_hdr(o_rx_hdr),
    .o_rx_data_valid(o_rx_data_valid), .o_rx_hdr_valid(o_rx_hdr_valid)
  );

  int n_run = 0;
  int n_fail = 0;

  // Reference model: the window/tolerance rules applied per header event.
  bit            m_lock, m_slip, m_waiting, m_dv, m_hv;
  int            m_sh, m_inv, m_wait;
  logic [DW-1:0] m_data;
  logic [HW-1:0] m_hdr;

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
  endfunction

  // Apply one cycle of inputs and advance the model. The DUT is sampled
  // 1 ns after the edge.
  task automatic step(input bit r, input bit hv, input logic [1:0] h,
                      input bit dv, input logic [DW-1:0] d);
    bit lock_pre;
    bit bad;
    lock_pre = m_lock;
    rst = r; rx_hv = hv; rx_hdr = h; rx_dv = dv; rx_data = d;
    @(posedge clk);
    #1;
    m_slip = 0;
    if (r) begin
      m_lock = 0; m_waiting = 0; m_dv = 0; m_hv = 0;
      m_sh = 0; m_inv = 0; m_wait = 0; m_data = '0; m_hdr = '0;
    end else begin
      m_data = d; m_hdr = h;
      m_dv = dv && lock_pre;
      m_hv = hv && lock_pre;
      if (hv) begin
        if (m_waiting) begin
          m_wait++;
          if (m_wait >= WAIT_HDRS) begin m_wait = 0; m_waiting = 0; end
        end else begin
          bad = (h != 2'b01) && (h != 2'b10);
          m_sh++;
          if (bad) m_inv++;
          if (bad && (!m_lock || m_inv == INV_MAX)) begin
            m_slip = 1; m_lock = 0; m_sh = 0; m_inv = 0; m_waiting = 1;
          end else if (m_sh == SH_MAX) begin
            if (m_inv == 0) m_lock = 1;
            m_sh = 0; m_inv = 0;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    step(1, 0, 2'b00, 0, '0);
    step(1, 1, 2'b11, 1, 32'hFFFF_FFFF);
    n_run++;
    if ({o_slip, o_block_lock, o_rx_data_valid, o_rx_hdr_valid, o_rx_data, o_rx_hdr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got slip=%b lock=%b dv=%b hv=%b data=%h hdr=%b, want all 0",
               o_slip, o_block_lock, o_rx_data_valid, o_rx_hdr_valid, o_rx_data, o_rx_hdr);
    end
  endtask

  task automatic test_lock();
    int slips = 0;
    step(1, 0, 2'b00, 0, '0);
    for (int i = 1; i <= SH_MAX; i++) begin
      step(0, 1, good_hdr(), 1, $urandom);
      if (o_slip) slips++;
      n_run++;
      if ({o_slip, o_block_lock, o_rx_data_valid, o_rx_hdr_valid} !== {m_slip, m_lock, m_dv, m_hv}) begin
        n_fail++;
        $display("FAIL lock_model hdr %0d: got %b want %b", i,
                 {o_slip, o_block_lock, o_rx_data_valid, o_rx_hdr_valid}, {m_slip, m_lock, m_dv, m_hv});
      end
      n_run++;
      if (o_block_lock !== (i == SH_MAX)) begin
        n_fail++;
        $display("FAIL lock_timing hdr %0d: got lock=%b want %b", i, o_block_lock, (i == SH_MAX));
      end
      if (i == SH_MAX) begin
        // the header that grants lock is not forwarded as valid
        n_run++;
        if (o_rx_data_valid !== 1'b0 || o_rx_hdr_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL lock_gate_pre: got dv=%b hv=%b want 0 0", o_rx_data_valid, o_rx_hdr_valid);
        end
      end
      step(0, 0, 2'b00, 0, '0);
      if (o_slip) slips++;
    end
    n_run++;
    if (slips != 0) begin
      n_fail++;
      $display("FAIL lock_no_slip: got %0d slips want 0", slips);
    end
  endtask

  task automatic test_slip_unlocked();
    step(1, 0, 2'b00, 0, '0);
    for (int i = 1; i <= 9; i++) step(0, 1, good_hdr(), 0, '0);
    step(0, 1, 2'b00, 0, '0);
    n_run++;
    if (o_slip !== 1'b1 || o_block_lock !== 1'b0 || m_slip !== 1'b1) begin
      n_fail++;
      $display("FAIL slip_pulse: got slip=%b lock=%b want 1 0", o_slip, o_block_lock);
    end
    step(0, 0, 2'b00, 0, '0);
    n_run++;
    if (o_slip !== 1'b0) begin
      n_fail++;
      $display("FAIL slip_one_cycle: got slip=%b want 0", o_slip);
    end
    for (int i = 0; i < WAIT_HDRS; i++) begin
      step(0, 1, 2'b11, 0, '0);
      n_run++;
      if (o_slip !== 1'b0) begin
        n_fail++;
        $display("FAIL slip_wait_ignore %0d: got slip=%b want 0", i, o_slip);
      end
    end
    for (int i = 1; i <= SH_MAX; i++) begin
      step(0, 1, good_hdr(), 0, '0);
      n_run++;
      if ({o_slip, o_block_lock} !== {m_slip, m_lock}) begin
        n_fail++;
        $display("FAIL relock_model hdr %0d: got %b want %b", i, {o_slip, o_block_lock}, {m_slip, m_lock});
      end
    end
    n_run++;
    if (o_block_lock !== 1'b1) begin
      n_fail++;
      $display("FAIL relock: got lock=%b want 1", o_block_lock);
    end
  endtask

  task automatic test_tolerance();
    bit flags[SH_MAX];
    int slips, nbad, j;
    bit t;
    step(1, 0, 2'b00, 0, '0);
    for (int i = 0; i < SH_MAX; i++) step(0, 1, good_hdr(), 0, '0);
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < SH_MAX; i++) flags[i] = (i < INV_MAX - 1 + w);
      for (int i = SH_MAX - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = flags[i]; flags[i] = flags[j]; flags[j] = t;
      end
      slips = 0; nbad = 0;
      for (int i = 0; i < SH_MAX; i++) begin
        step(0, 1, flags[i] ? 2'b11 : good_hdr(), 1, $urandom);
        if (flags[i]) nbad++;
        if (o_slip) slips++;
        n_run++;
        if ({o_slip, o_block_lock, o_rx_data_valid} !== {m_slip, m_lock, m_dv}) begin
          n_fail++;
          $display("FAIL tol_model win %0d hdr %0d: got %b want %b", w, i,
                   {o_slip, o_block_lock, o_rx_data_valid}, {m_slip, m_lock, m_dv});
        end
        if (w == 1 && nbad == INV_MAX) begin
          n_run++;
          if (o_slip !== 1'b1 || o_block_lock !== 1'b0) begin
            n_fail++;
            $display("FAIL tol_16th: got slip=%b lock=%b want 1 0", o_slip, o_block_lock);
          end
          break;
        end
      end
      if (w == 0) begin
        n_run++;
        if (o_block_lock !== 1'b1 || slips != 0) begin
          n_fail++;
          $display("FAIL tol_15: got lock=%b slips=%0d want 1 0", o_block_lock, slips);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int slips = 0;
    bit prev = 0;
    step(1, 0, 2'b00, 0, '0);
    for (int i = 1; i <= 20; i++) begin
      step(0, 1, bad_hdr(), 0, '0);
      n_run++;
      if (o_slip !== m_slip) begin
        n_fail++;
        $display("FAIL b2b_model ev %0d: got slip=%b want %b", i, o_slip, m_slip);
      end
      n_run++;
      if (prev && o_slip) begin
        n_fail++;
        $display("FAIL b2b_consecutive ev %0d: got slip high twice, want never", i);
      end
      prev = o_slip;
      if (o_slip) slips++;
    end
    n_run++;
    if (slips != 7) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d slips want 7", slips);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 2'b00, 0, '0);
    for (int i = 0; i < 40; i++) begin
      step(0, 1, good_hdr(), 1, $urandom);
      if ($urandom_range(0, 1) == 1) step(0, 0, 2'b00, 1, $urandom);
    end
    step(1, 1, 2'b01, 1, $urandom);
    n_run++;
    if ({o_slip, o_block_lock, o_rx_data_valid, o_rx_hdr_valid, o_rx_data, o_rx_hdr} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got slip=%b lock=%b data=%h, want all 0", o_slip, o_block_lock, o_rx_data);
    end
    for (int i = 1; i <= SH_MAX; i++) begin
      step(0, 1, good_hdr(), 0, '0);
      n_run++;
      if (o_block_lock !== (i == SH_MAX)) begin
        n_fail++;
        $display("FAIL midreset_relock hdr %0d: got lock=%b want %b", i, o_block_lock, (i == SH_MAX));
      end
    end
    // reset during SLIP_WAIT: the next bad header must be evaluated at once
    step(1, 0, 2'b00, 0, '0);
    step(0, 1, 2'b00, 0, '0);
    step(1, 1, 2'b01, 0, '0);
    step(0, 1, 2'b11, 0, '0);
    n_run++;
    if (o_slip !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_wait: got slip=%b want 1", o_slip);
    end
  endtask

  task automatic test_data();
    step(1, 0, 2'b00, 0, '0);
    step(0, 0, 2'b01, 1, 32'hDEADBEEF);
    n_run++;
    if (o_rx_data_valid !== 1'b0 || o_rx_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL data_unlocked: got dv=%b data=%h want 0 deadbeef", o_rx_data_valid, o_rx_data);
    end
    for (int i = 0; i < SH_MAX; i++) step(0, 1, good_hdr(), 0, '0);
    step(0, 1, 2'b10, 1, 32'hDEADBEEF);
    n_run++;
    if (o_rx_data_valid !== 1'b1 || o_rx_hdr_valid !== 1'b1 || o_rx_data !== 32'hDEADBEEF || o_rx_hdr !== 2'b10) begin
      n_fail++;
      $display("FAIL data_locked: got dv=%b hv=%b data=%h hdr=%b want 1 1 deadbeef 10",
               o_rx_data_valid, o_rx_hdr_valid, o_rx_data, o_rx_hdr);
    end
  endtask

  task automatic test_random();
    bit r, hv;
    int err_pct;
    logic [1:0] h;
    step(1, 0, 2'b00, 0, '0);
    for (int c = 0; c < 4000; c++) begin
      err_pct = (c < 2000) ? 1 : 12;
      r  = ($urandom_range(0, 499) == 0);
      hv = ($urandom_range(0, 9) < 7);
      h  = ($urandom_range(0, 99) < err_pct) ? bad_hdr() : good_hdr();
      step(r, hv, h, $urandom_range(0, 1), $urandom);
      n_run++;
      if ({o_slip, o_block_lock, o_rx_data_valid, o_rx_hdr_valid} !== {m_slip, m_lock, m_dv, m_hv} ||
          (m_dv && o_rx_data !== m_data) || (m_hv && o_rx_hdr !== m_hdr)) begin
        n_fail++;
        $display("FAIL random cyc %0d: got ctl=%b data=%h hdr=%b want ctl=%b data=%h hdr=%b", c,
                 {o_slip, o_block_lock, o_rx_data_valid, o_rx_hdr_valid}, o_rx_data, o_rx_hdr,
                 {m_slip, m_lock, m_dv, m_hv}, m_data, m_hdr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_slip_unlocked();
    test_tolerance();
    test_back_to_back();
    test_reset_mid();
    test_data();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/rx_block_lock.md
Name: rx_block_lock

Overview:
- Receive-path block-lock state machine, IEEE 802.3 Clause 49 style, sitting directly downstream of the Rx block-sync gearbox.
- Inspects each 2-bit sync header the gearbox produces and decides whether 66-bit block alignment is achieved.
- Issues single-cycle i_slip pulses back to the gearbox until lock is reached.
- Forwards data and headers to the descrambler/decoder, qualified by lock.

Parameters:
- DATA_WIDTH, 32, width of gearbox data word.
- HDR_WIDTH, 2, sync header width.
- SH_CNT_MAX, 64, headers per evaluation window.
- SH_INVALID_MAX, 16, invalid headers in one window that force loss of lock.
- SLIP_WAIT_HDRS, 2, header events ignored after a slip while the gearbox realigns.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_rx_data  in  DATA_WIDTH  data word from gearbox
- i_rx_data_valid  in  1  i_rx_data valid this cycle
- i_rx_hdr  in  HDR_WIDTH  sync header from gearbox
- i_rx_hdr_valid  in  1  i_rx_hdr valid this cycle; asserted once per 66-bit block
- o_slip  out  1  one-cycle slip request to gearbox (drives its i_slip)
- o_block_lock  out  1  block alignment achieved
- o_rx_data  out  DATA_WIDTH  registered copy of i_rx_data
- o_rx_hdr  out  HDR_WIDTH  registered copy of i_rx_hdr
- o_rx_data_valid  out  1  registered i_rx_data_valid AND o_block_lock
- o_rx_hdr_valid  out  1  registered i_rx_hdr_valid AND o_block_lock

Behaviour:
- Single clock domain. i_reset is sampled on the i_clk edge only; no asynchronous path.
- Reset values: all outputs 0; sh_cnt = 0; inv_cnt = 0; wait_cnt = 0; state = TEST.
- Header classification: 2'b01 and 2'b10 are valid; 2'b00 and 2'b11 are invalid.
- sh_cnt width is $clog2(SH_CNT_MAX+1). inv_cnt width is $clog2(SH_INVALID_MAX+1). Counters never wrap; they are cleared at window end or on slip.
- States: TEST, SLIP_WAIT.
- TEST, i_rx_hdr_valid = 0: no change.
- TEST, i_rx_hdr_valid = 1:
  - sh_nxt = sh_cnt + 1.
  - inv_nxt = inv_cnt + (header invalid).
- TEST decision, evaluated in priority order on the same cycle using the _nxt values:
  1. Header invalid AND (o_block_lock = 0 OR inv_nxt = SH_INVALID_MAX): next cycle o_slip = 1 and o_block_lock = 0; counters cleared; go to SLIP_WAIT.
  2. Else if sh_nxt = SH_CNT_MAX: if inv_nxt = 0, set o_block_lock = 1; otherwise o_block_lock keeps its value. Counters cleared; stay in TEST.
  3. Else: store sh_nxt and inv_nxt.
- Rule 1 means an unlocked receiver slips on the first invalid header.
- A locked receiver tolerates up to SH_INVALID_MAX-1 invalid headers per window.
- o_slip is high for exactly one cycle per slip event. It is never asserted on two consecutive cycles, which is a gearbox requirement.
- SLIP_WAIT:
  - Each i_rx_hdr_valid increments wait_cnt; these headers are not evaluated.
  - When wait_cnt reaches SLIP_WAIT_HDRS: clear wait_cnt, return to TEST with counters 0.
- Latency:
  - o_slip and o_block_lock change 1 cycle after the deciding header is sampled.
  - The data/header path is a 1-cycle register.
  - Valid gating uses the pre-update o_block_lock value of the sampling cycle.
- o_rx_data and o_rx_hdr update every cycle regardless of valid. Their contents are don't-care when the matching valid output is 0.
- i_rx_data_valid without i_rx_hdr_valid is legal; it is passed through with no effect on the FSM.
- Reset asserted mid-window or mid-SLIP_WAIT: returns to reset values on the next edge. Any pending slip is cancelled.

Test Plan:
- Reset, then 64 valid headers (2'b01/2'b10 mixed), hdr_valid every other cycle -> o_block_lock 0 through the 64th header, 1 one cycle after it; o_slip never asserted.
- Unlocked, 2'b00 at header 10 -> o_slip 1 for one cycle, one cycle after that header. Next 2 headers ignored. Then 64 valid headers -> o_block_lock = 1.
- Locked, 15 invalid (2'b11) within one 64-header window -> o_block_lock stays 1, no slip. A window containing 16 invalid -> o_slip pulse and o_block_lock = 0 one cycle after the 16th.
- Unlocked, invalid headers on every header event for 20 events -> o_slip pulses are separated by SLIP_WAIT_HDRS ignored headers and are never high on consecutive cycles.
- 40 valid headers, then i_reset for 1 cycle -> all outputs 0 next edge. A further 64 valid headers are required before o_block_lock = 1.
- Data pass-through: i_rx_data = 32'hDEADBEEF with valid while unlocked -> o_rx_data_valid = 0. After lock -> o_rx_data = 32'hDEADBEEF with o_rx_data_valid = 1, one cycle later.
